// File: rtl/fp_11_10_pkg.sv
// ============================================================================
// Module  : fp_11_10_pkg
// Brief   : Shared widths, exception codes and word layout of FloPoCo 11_10.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_11_10_pkg;

   localparam int WE    = 11;
   localparam int WF    = 10;
   localparam int IN_W  = WE + WF + 1;
   localparam int FLO_W = WE + WF + 3;

   // FloPoCo word layout: {exc[1:0], sign, exponent, fraction}
   localparam int EXP_LSB  = WF;
   localparam int SIGN_POS = WE + WF;
   localparam int EXC_LSB  = WE + WF + 1;

   localparam logic [1:0] EXC_ZERO   = 2'b00;
   localparam logic [1:0] EXC_NORMAL = 2'b01;
   localparam logic [1:0] EXC_INF    = 2'b10;
   localparam logic [1:0] EXC_NAN    = 2'b11;

   // Special values carry only exc and sign; NaN also drops the sign.
   function automatic logic [FLO_W-1:0] fp_assemble(
      input logic [1:0]      exc,
      input logic            ftz,
      input logic [IN_W-1:0] word
   );
      logic [FLO_W-1:0] r;
      r = '0;
      r[EXC_LSB +: 2] = ftz ? EXC_ZERO : exc;
      if (exc == EXC_NORMAL && !ftz) begin
         r[IN_W-1:0] = word;
      end else if (exc != EXC_NAN) begin
         r[SIGN_POS] = word[SIGN_POS];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fp_encode_11_10_if.sv
// ============================================================================
// Module  : fp_encode_11_10_if
// Brief   : Ingress and egress valid/ready streams of the 11_10 encoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fp_encode_11_10_if
   import fp_11_10_pkg::*;
();

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [FLO_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

`default_nettype wire

// File: rtl/fp_classify_11_10.sv
// ============================================================================
// Module  : fp_classify_11_10
// Brief   : Combinational exception classifier; flags subnormals for flush.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_classify_11_10
   import fp_11_10_pkg::*;
(
   input  logic [WE-1:0] exponent,
   input  logic [WF-1:0] fraction,
   output logic [1:0]    exc,
   output logic          ftz
);

   logic w_frac_nz;

   assign w_frac_nz = |fraction;

   always_comb begin
      exc = EXC_NORMAL;
      ftz = 1'b0;
      if (exponent == '0) begin
         exc = EXC_ZERO;
         ftz = w_frac_nz;
      end else if (exponent == '1) begin
         exc = w_frac_nz ? EXC_NAN : EXC_INF;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fp_encode_11_10.sv
// ============================================================================
// Module  : fp_encode_11_10
// Brief   : Two-stage IEEE 1/11/10 to FloPoCo 11_10 encoder on valid/ready.
//           Optional event counters under FPENC_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_encode_11_10
   import fp_11_10_pkg::*;
`ifdef FPENC_STATS_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic                  clk,
   input  logic                  rst,
   fp_encode_11_10_if.slave      s_if
`ifdef FPENC_STATS_EN
   ,
   input  logic                  stats_clr,
   output logic [CNT_W-1:0]      cnt_zero,
   output logic [CNT_W-1:0]      cnt_inf,
   output logic [CNT_W-1:0]      cnt_nan,
   output logic [CNT_W-1:0]      cnt_ftz
`endif
);

   logic             w_s1_adv;
   logic             w_s2_adv;
   logic [1:0]       w_exc;
   logic             w_ftz;

   logic             r_s1_valid;
   logic [IN_W-1:0]  r_s1_word;
   logic [1:0]       r_s1_exc;
   logic             r_s1_ftz;

   logic             r_s2_valid;
   logic [FLO_W-1:0] r_s2_word;

   // Ready ripples back combinationally so a released stall costs no bubble.
   assign w_s2_adv      = !r_s2_valid || s_if.out_ready;
   assign w_s1_adv      = !r_s1_valid || w_s2_adv;
   assign s_if.in_ready = w_s1_adv;
   assign s_if.out_valid = r_s2_valid;
   assign s_if.out_data  = r_s2_word;

   fp_classify_11_10 u_classify (
      .exponent (s_if.in_data[EXP_LSB +: WE]),
      .fraction (s_if.in_data[WF-1:0]),
      .exc      (w_exc),
      .ftz      (w_ftz)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_word  <= '0;
         r_s1_exc   <= EXC_ZERO;
         r_s1_ftz   <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= s_if.in_valid;
         if (s_if.in_valid) begin
            r_s1_word <= s_if.in_data;
            r_s1_exc  <= w_exc;
            r_s1_ftz  <= w_ftz;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_word  <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_word <= fp_assemble(r_s1_exc, r_s1_ftz, r_s1_word);
         end
      end
   end

`ifdef FPENC_STATS_EN
   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic       r_s2_ftz;
   logic       w_xfer;
   logic [1:0] w_out_exc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_ftz <= 1'b0;
      end else if (w_s2_adv && r_s1_valid) begin
         r_s2_ftz <= r_s1_ftz;
      end
   end

   assign w_xfer    = r_s2_valid && s_if.out_ready;
   assign w_out_exc = r_s2_word[EXC_LSB +: 2];

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v,
      input logic             ev
   );
      return (ev && v != c_cnt_max) ? v + c_cnt_one : v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst || stats_clr) begin
         cnt_zero <= '0;
         cnt_inf  <= '0;
         cnt_nan  <= '0;
         cnt_ftz  <= '0;
      end else begin
         cnt_zero <= sat_inc(cnt_zero, w_xfer && w_out_exc == EXC_ZERO && !r_s2_ftz);
         cnt_inf  <= sat_inc(cnt_inf,  w_xfer && w_out_exc == EXC_INF);
         cnt_nan  <= sat_inc(cnt_nan,  w_xfer && w_out_exc == EXC_NAN);
         cnt_ftz  <= sat_inc(cnt_ftz,  w_xfer && r_s2_ftz);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_encode_11_10.sv
// ============================================================================
// Module  : tb_fp_encode_11_10
// Brief   : Scoreboard bench for fp_encode_11_10 (counters with FPENC_STATS_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_encode_11_10;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   logic [23:0] exp_q[$];

   fp_encode_11_10_if bus ();

`ifdef FPENC_STATS_EN
   logic        stats_clr;
   logic [15:0] cnt_zero, cnt_inf, cnt_nan, cnt_ftz;
`endif

   fp_encode_11_10 dut (
      .clk       (clk),
      .rst       (rst),
      .s_if      (bus.slave)
`ifdef FPENC_STATS_EN
      ,
      .stats_clr (stats_clr),
      .cnt_zero  (cnt_zero),
      .cnt_inf   (cnt_inf),
      .cnt_nan   (cnt_nan),
      .cnt_ftz   (cnt_ftz)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [23:0] model(input logic [21:0] d);
      logic        s;
      logic [10:0] e;
      logic [9:0]  f;
      s = d[21];
      e = d[20:10];
      f = d[9:0];
      if (e == 11'h000) return {2'b00, s, 21'h0};
      if (e == 11'h7FF) return (f != 10'h0) ? 24'hC00000 : {2'b10, s, 21'h0};
      return {2'b01, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [21:0] d, input logic [23:0] e);
      logic got;
      got = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (bus.in_ready) got = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("send_accept", 32'(got), 1);
      if (got) begin
         @(posedge clk);
         exp_q.push_back(e);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      #1;
      check("drain_empty", 32'(exp_q.size()), 0);
   endtask

   // Monitor: occupancy-derived ready, stall stability, in-order scoreboard.
   initial begin
      logic        prev_stall;
      logic [23:0] prev_data;
      logic [23:0] e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            check("in_ready", 32'(bus.in_ready),
                  32'(!(exp_q.size() == 2 && !bus.out_ready)));
            if (prev_stall) begin
               check("stall_valid", 32'(bus.out_valid), 1);
               check("stall_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
               check("sb_nonempty", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("out_data", 32'(bus.out_data), 32'(e));
               end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
         end
      end
   end

   initial begin
      logic [21:0] bp_words [8];
      logic        acc, saw_low;
      int          idx;

      n_cmp = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
`ifdef FPENC_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_data", 32'(bus.out_data), 0);
      check("rst_in_ready", 32'(bus.in_ready), 1);
      @(posedge clk);
      #1 rst = 1'b0;

      // Latency: word presented before edge k visible after edge k+1.
      send(22'h0FFC00, 24'h4FFC00);
      check("lat_s1_only", 32'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      check("lat_out_valid", 32'(bus.out_valid), 1);
      check("lat_out_data", 32'(bus.out_data), 32'h4FFC00);

      send(22'h300000, 24'h700000);
      send(22'h1FFC00, 24'h800000);
      send(22'h1FFC01, 24'hC00000);
      send(22'h000000, 24'h000000);
      send(22'h200001, 24'h200000);
      drain();
`ifdef FPENC_STATS_EN
      check("cnt_ftz", 32'(cnt_ftz), 1);
      check("cnt_zero", 32'(cnt_zero), 1);
      check("cnt_inf", 32'(cnt_inf), 1);
      check("cnt_nan", 32'(cnt_nan), 1);
      stats_clr = 1'b1;
      send(22'h000000, 24'h000000);
      drain();
      stats_clr = 1'b0;
      check("clr_wins", 32'(cnt_zero), 0);
`endif

      // Backpressure: out_ready low for cycles 3..6 of an 8-word stream.
      bp_words = '{22'h0FFC00, 22'h300000, 22'h1FFC00, 22'h1FFC01,
                   22'h200001, 22'h155555, 22'h0AAAAA, 22'h3FFFFF};
      idx = 0;
      saw_low = 1'b0;
      for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
         bus.out_ready = !(cyc >= 3 && cyc <= 6);
         bus.in_valid  = 1'b1;
         bus.in_data   = bp_words[idx];
         @(negedge clk);
         acc = bus.in_ready;
         if (!acc) saw_low = 1'b1;
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(model(bp_words[idx]));
            idx++;
         end
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_all_sent", 32'(idx), 8);
      check("bp_ready_dropped", 32'(saw_low), 1);
      drain();

      // Reset with both stages full: words are dropped, not replayed.
      bus.out_ready = 1'b0;
      send(22'h0FFC00, 24'h4FFC00);
      send(22'h300000, 24'h700000);
      check("full_occupancy", 32'(exp_q.size()), 2);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 0);
      check("midrst_in_ready", 32'(bus.in_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(bus.in_ready), 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("no_replay", 32'(bus.out_valid), 0);
      end

`ifdef FPENC_STATS_EN
      check("post_rst_cnt_zero", 32'(cnt_zero), 0);
      for (int i = 0; i < 65536 + 3; i++) send(22'h000000, 24'h000000);
      drain();
      check("cnt_zero_sat", 32'(cnt_zero), 32'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
